// File: rtl/mdu_alu.sv
// mdu_alu: clocked ALU with iterative unsigned mult/div, HI/LO registers and start/busy/done handshake
module mdu_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] lop,
  input  logic [WIDTH-1:0] rop,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_d, r_result, r_hi, r_lo;
  logic             r_div, r_busy, r_done, r_div_zero;
  logic [WIDTH-1:0] w_alu, w_n_acc, w_n_q;
  logic [WIDTH:0]   w_madd, w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_ge;
  always_comb begin
    w_alu   = op == 3'd0 ? lop + rop :
              op == 3'd1 ? lop - rop :
              op == 3'd2 ? lop & rop :
              op == 3'd3 ? lop | rop :
              op == 3'd4 ? WIDTH'(lop < rop) : '0;
    w_madd  = {1'b0, r_acc} + {1'b0, r_q[0] ? r_d : '0};
    w_shift = {r_acc, r_q[WIDTH-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_d};
    w_ge    = ~w_diff[WIDTH+1];
    w_n_acc = r_div ? (w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]) : w_madd[WIDTH:1];
    w_n_q   = r_div ? {r_q[WIDTH-2:0], w_ge} : {w_madd[0], r_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_q        <= '0;
      r_d        <= '0;
      r_div      <= 1'b0;
      r_result   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == RUN) begin
        r_acc <= w_n_acc;
        r_q   <= w_n_q;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          r_hi       <= w_n_acc;
          r_lo       <= w_n_q;
          r_result   <= w_n_q;
          r_done     <= 1'b1;
          r_div_zero <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= FIN;
        end
      end else begin
        r_state <= IDLE;
        if (start) begin
          if (op == 3'd5 || (op == 3'd6 && rop != '0)) begin
            r_acc   <= '0;
            r_q     <= lop;
            r_d     <= rop;
            r_div   <= op == 3'd6;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else if (op == 3'd6) begin
            r_lo       <= '1;
            r_hi       <= lop;
            r_result   <= '1;
            r_done     <= 1'b1;
            r_div_zero <= 1'b1;
          end else begin
            r_result   <= w_alu;
            r_done     <= 1'b1;
            r_div_zero <= 1'b0;
          end
        end
      end
    end
  end
  assign result   = r_result;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
endmodule

// File: tb/tb_mdu_alu.sv
// tb_mdu_alu: table-driven and scoreboard checks of mdu_alu at WIDTH 32 and 8
module tb_mdu_alu;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] lop = '0, rop = '0, result, hi, lo;
  logic        busy, done, div_zero;
  logic        start8 = 1'b0;
  logic [2:0]  op8 = '0;
  logic [7:0]  lop8 = '0, rop8 = '0, result8, hi8, lo8;
  logic        busy8, done8, dz8;
  mdu_alu #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .start(start), .op(op), .lop(lop), .rop(rop),
    .result(result), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero));
  mdu_alu #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start8), .op(op8), .lop(lop8), .rop(rop8),
    .result(result8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8), .div_zero(dz8));
  typedef struct {logic [31:0] res; logic [31:0] hi; logic [31:0] lo; logic dz;} exp_t;
  typedef struct {logic [2:0] op; logic [31:0] l; logic [31:0] r; exp_t e;} vec_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic run32(input logic [2:0] o, input logic [31:0] l, input logic [31:0] r, input exp_t e);
    exp_t g;
    int lat, el;
    el = (o == 3'd5 || (o == 3'd6 && r != 0)) ? 33 : 1;
    sb.push_back(e);
    @(negedge clk);
    chk("done_idle", 64'(done), 64'd0);
    start = 1'b1; op = o; lop = l; rop = r;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      chk("busy_run", 64'(busy), 64'(el > 1));
      @(negedge clk);
      lat++;
    end
    g = sb.pop_front();
    chk("latency", 64'(lat), 64'(el));
    chk("result", 64'(result), 64'(g.res));
    chk("hi", 64'(hi), 64'(g.hi));
    chk("lo", 64'(lo), 64'(g.lo));
    chk("div_zero", 64'(div_zero), 64'(g.dz));
    chk("busy_done", 64'(busy), 64'd0);
  endtask
  task automatic run8(input logic [2:0] o, input logic [7:0] l, input logic [7:0] r, input exp_t e);
    exp_t g;
    int lat, el;
    el = (o == 3'd5 || (o == 3'd6 && r != 0)) ? 9 : 1;
    sb.push_back(e);
    @(negedge clk);
    start8 = 1'b1; op8 = o; lop8 = l; rop8 = r;
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    g = sb.pop_front();
    chk("w8_latency", 64'(lat), 64'(el));
    chk("w8_result", 64'(result8), 64'(g.res));
    chk("w8_hi", 64'(hi8), 64'(g.hi));
    chk("w8_lo", 64'(lo8), 64'(g.lo));
    chk("w8_div_zero", 64'(dz8), 64'(g.dz));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[13];
    logic [63:0] p;
    logic [31:0] a, b;
    logic [2:0] o;
    int nd;
    tbl[0]  = '{3'd0, 32'hFFFFFFFF, 32'd1,        '{32'h0,        32'h0,        32'h0,        1'b0}};
    tbl[1]  = '{3'd1, 32'd3,        32'd5,        '{32'hFFFFFFFE, 32'h0,        32'h0,        1'b0}};
    tbl[2]  = '{3'd4, 32'd2,        32'h80000000, '{32'h1,        32'h0,        32'h0,        1'b0}};
    tbl[3]  = '{3'd7, 32'd1,        32'd2,        '{32'h0,        32'h0,        32'h0,        1'b0}};
    tbl[4]  = '{3'd2, 32'hF0F0F0F0, 32'hFF00FF00, '{32'hF000F000, 32'h0,        32'h0,        1'b0}};
    tbl[5]  = '{3'd3, 32'h0F0F0000, 32'h000000FF, '{32'h0F0F00FF, 32'h0,        32'h0,        1'b0}};
    tbl[6]  = '{3'd4, 32'h80000000, 32'd2,        '{32'h0,        32'h0,        32'h0,        1'b0}};
    tbl[7]  = '{3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, '{32'h1,        32'hFFFFFFFE, 32'h1,        1'b0}};
    tbl[8]  = '{3'd6, 32'd100,      32'd7,        '{32'd14,       32'd2,        32'd14,       1'b0}};
    tbl[9]  = '{3'd6, 32'd5,        32'd0,        '{32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 1'b1}};
    tbl[10] = '{3'd0, 32'd7,        32'd8,        '{32'd15,       32'd5,        32'hFFFFFFFF, 1'b0}};
    tbl[11] = '{3'd5, 32'h12345678, 32'h10,       '{32'h23456780, 32'h1,        32'h23456780, 1'b0}};
    tbl[12] = '{3'd6, 32'hFFFFFFFF, 32'h10000,    '{32'hFFFF,     32'hFFFF,     32'hFFFF,     1'b0}};
    #1;
    chk("rst_out32", {result, hi}, 64'd0);
    chk("rst_lo_status", {lo, 29'd0, busy, done, div_zero}, 64'd0);
    chk("rst_out8", {32'd0, result8, hi8, lo8, 5'd0, busy8, done8, dz8}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 13; i++) run32(tbl[i].op, tbl[i].l, tbl[i].r, tbl[i].e);
    for (int i = 0; i < 6; i++) begin
      o = (i % 2 == 0) ? 3'd5 : 3'd6;
      a = $urandom;
      b = (i > 3) ? 32'($urandom_range(1, 255)) : $urandom | 32'd1;
      p = 64'(a) * 64'(b);
      if (o == 3'd5) run32(o, a, b, '{p[31:0], p[63:32], p[31:0], 1'b0});
      else run32(o, a, b, '{a / b, a % b, a / b, 1'b0});
    end
    // start pulsed mid-multiply is ignored; start in the done cycle is taken
    a = 32'hDEADBEEF;
    b = 32'h1234;
    p = 64'(a) * 64'(b);
    @(negedge clk);
    start = 1'b1; op = 3'd5; lop = a; rop = b;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'd0; lop = 32'd1; rop = 32'd2;
    @(negedge clk);
    start = 1'b0;
    nd = 11;
    while (!done && nd < 100) begin
      @(negedge clk);
      nd++;
    end
    chk("ign_latency", 64'(nd), 64'd33);
    chk("ign_result", 64'(result), 64'(p[31:0]));
    chk("ign_prod", {hi, lo}, p);
    chk("ign_busy", 64'(busy), 64'd0);
    start = 1'b1; op = 3'd0; lop = 32'd10; rop = 32'd20;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_result", 64'(result), 64'd30);
    chk("b2b_prod_kept", {hi, lo}, p);
    @(negedge clk);
    chk("b2b_done_once", 64'(done), 64'd0);
    // reset in the middle of a divide aborts it
    start = 1'b1; op = 3'd6; lop = 32'd1000; rop = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out", {result, hi}, 64'd0);
    chk("mid_rst_lo_status", {lo, 29'd0, busy, done, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    chk("no_done_after_rst", 64'(nd), 64'd0);
    run32(3'd5, 32'd6, 32'd7, '{32'd42, 32'd0, 32'd42, 1'b0});
    run8(3'd0, 8'hFF, 8'h01, '{32'h0, 32'h0, 32'h0, 1'b0});
    run8(3'd5, 8'hFF, 8'h02, '{32'hFE, 32'h01, 32'hFE, 1'b0});
    run8(3'd6, 8'hFF, 8'h10, '{32'h0F, 32'h0F, 32'h0F, 1'b0});
    run8(3'd6, 8'h37, 8'h00, '{32'hFF, 32'h37, 32'hFF, 1'b1});
    run8(3'd1, 8'h02, 8'h05, '{32'hFD, 32'h37, 32'hFF, 1'b0});
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
